// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 keypad responder; latches key_in on key_valid&key_ready, presses it (bounce/hold/gap), drives active-low row from active-low col
module keypad_emulator #(
  parameter int BOUNCE_CYCLES = 0,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       abort,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       pressed,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, GAP} state_t;
  localparam logic [15:0] BC = 16'(BOUNCE_CYCLES);
  localparam logic [15:0] HC = 16'(HOLD_CYCLES);
  localparam logic [15:0] GC = 16'(GAP_CYCLES);
  localparam logic [63:0] MAP = 64'h7BFEDCA629518403;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0] key, cr;
  logic [1:0] ph;
  logic pressed_n, done_n, accept, last;
  assign key_ready = state == IDLE;
  assign busy = !key_ready;
  assign accept = key_valid && key_ready;
  assign last = cnt == 16'd1;
  assign ph = BC[1:0] - cnt[1:0] + 2'd1;
  assign cr = MAP[{key, 2'b00} +: 4];
  always_comb begin
    state_n = state;
    cnt_n = cnt - 16'd1;
    pressed_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = accept ? (BC != 16'd0 ? BOUNCE : HOLD) : IDLE;
        cnt_n = accept ? (BC != 16'd0 ? BC : HC) : cnt;
        pressed_n = accept;
      end
      BOUNCE: begin
        state_n = abort ? GAP : last ? HOLD : BOUNCE;
        cnt_n = abort ? GC : last ? HC : cnt - 16'd1;
        pressed_n = !abort && (last || ph < 2'd2);
      end
      HOLD: begin
        state_n = (abort || last) ? GAP : HOLD;
        cnt_n = (abort || last) ? GC : cnt - 16'd1;
        pressed_n = !(abort || last);
      end
      default: begin
        state_n = last ? IDLE : GAP;
        cnt_n = last ? 16'd0 : cnt - 16'd1;
        done_n = last;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      key <= '0;
      pressed <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pressed <= pressed_n;
      done <= done_n;
      if (accept) key <= key_in;
    end
  always_comb begin
    row = 4'hF;
    if (pressed && !col[cr[3:2]]) row[cr[1:0]] = 1'b0;
  end
endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesizable model of a 4x4 matrix keypad: the responder side of the column-scan/row-sense interface.
- Accepts a key code over a valid/ready handshake, then "presses" that key for a programmed time, with optional contact bounce, and releases it.
- Drives active-low row lines in response to the active-low column strobes from a matrix-keypad scanner.
- Used for in-system self-test and closed-loop simulation of the keypad path without a physical keypad.

Parameters:
BOUNCE_CYCLES, 0, cycles of contact chatter at press start; 0 disables bounce.
HOLD_CYCLES, 16, cycles contact stays solidly closed after bounce; must be at least 1.
GAP_CYCLES, 16, cycles contact stays open after release before the next key is accepted; must be at least 1.
All three parameters must be at most 65535; counters are 16 bits.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
key_in  input  4  key code to press (0x0..0xF)
key_valid  input  1  key_in is valid
key_ready  output  1  emulator can accept a key; high only in IDLE
abort  input  1  synchronous; forces immediate release
col  input  4  column strobes from scanner, active-low
row  output  4  row sense lines, active-low, 4'hF = no contact
pressed  output  1  contact currently closed
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when a press/gap sequence completes

Behaviour:
- Reset (async, rst=1): state IDLE, latched key 0, counter 0, pressed=0, done=0, busy=0, key_ready=1, row=4'hF immediately and independent of col.
- Key map (code -> column index c, row index r):
  - col0: 1,4,7,0 -> r 0,1,2,3
  - col1: 2,5,8,F -> r 0..3
  - col2: 3,6,9,E -> r 0..3
  - col3: A,B,C,D -> r 0..3
  - The decode is fixed combinational logic applied to the latched code.
- Row generation (zero-latency combinational path from col):
  - row[r] = 0 iff pressed=1 and col[c]=0; all other row bits are 1.
  - col=4'h0 with a key pressed therefore shows that key's row bit low.
  - Multiple low col bits are allowed.
  - pressed is registered.
- Handshake: accept on a rising edge with key_valid=1 and key_ready=1. key_in is latched on that edge; key_in changes outside acceptance are ignored.
- State machine (the counter loads on each state entry and counts down to 1):
  - IDLE:
    - On accept: go to BOUNCE with count BOUNCE_CYCLES if BOUNCE_CYCLES>0, else to HOLD with count HOLD_CYCLES.
  - BOUNCE:
    - pressed = NOT bit1 of the elapsed-cycle index, i.e. the pattern 1,1,0,0,1,1,... starting with the first BOUNCE cycle.
    - After BOUNCE_CYCLES cycles: go to HOLD.
  - HOLD:
    - pressed=1 for exactly HOLD_CYCLES cycles, then go to GAP.
  - GAP:
    - pressed=0 for exactly GAP_CYCLES cycles, then go to IDLE.
    - done=1 in the first IDLE cycle only.
- Timing: with bounce off, pressed rises in the cycle after acceptance, stays high HOLD_CYCLES cycles, and key_ready returns HOLD_CYCLES+GAP_CYCLES cycles after pressed rose.
- abort:
  - In BOUNCE or HOLD: next state is GAP with a full GAP_CYCLES count, and pressed=0 next cycle.
  - In GAP or IDLE: no effect.
  - abort together with acceptance in IDLE: acceptance wins, abort is ignored.
- busy = (state != IDLE). key_ready = (state == IDLE); it is not gated by abort.
- Reset mid-sequence: row goes to 4'hF and pressed goes to 0 immediately; no done pulse.

Test Plan:
- Map check, bounce=0, HOLD=8: press key 5, hold col=1101 -> row=1101. col=1110 -> row=4'hF. col=0000 -> row=1101. Repeat for D (col=0111 -> row=0111) and 0 (col=1110 -> row=0111).
- Timing, HOLD=8, GAP=4:
  - Accept key 3 at edge T; pressed is high for cycles T+1..T+8.
  - key_ready=0 until T+13; done pulses at T+13 only.
  - key_valid held high through the sequence accepts a second key exactly at T+13.
- Bounce, BOUNCE=6, HOLD=4: pressed sequence after accept is 1,1,0,0,1,1,1,1,1,1, then 0. row follows pressed for a matching col.
- Abort at HOLD cycle 3: pressed=0 next cycle, GAP lasts a full GAP_CYCLES, done pulses, then key_ready=1. Abort asserted in IDLE with key_valid: key accepted normally.
- Async reset asserted mid-HOLD between clock edges: row=4'hF and pressed=0 without waiting for clk. After release, key_ready=1 and no done pulse.
- Closed loop with a matrix-keypad scanner on the same clk, HOLD=32:
  - Press 9: scanner key value becomes 4'h9 while held.
  - Then press A: it becomes 4'hA.
  - Row returns to 4'hF during GAP.
